// File: rtl/ifstmt_seq_accum_pkg.sv
// Shared encodings and helper functions for the sequential if/else accumulator.
// The eq() helper keeps the step selection written as explicit equality calls.
package ifstmt_seq_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] MODE_ADD  = 2'd0;
   localparam logic [1:0] MODE_ADD1 = 2'd1;
   localparam logic [1:0] MODE_INC2 = 2'd2;
   localparam logic [1:0] MODE_HOLD = 2'd3;

   function automatic logic eq(input logic [31:0] p, input logic [31:0] q);
      return (p == q);
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ifstmt_seq_accum_if.sv
// Start/mode/operand inputs and result/status outputs of the accumulator.
interface ifstmt_seq_accum_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       sel;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] a;
   logic             busy;
   logic             done;

   modport master (output start, sel, x, input a, busy, done);
   modport slave  (input start, sel, x, output a, busy, done);
endinterface

// File: rtl/ifstmt_seq_accum_step.sv
// One accumulation step: nested if/else chain over the latched mode and step count.
module ifstmt_seq_step
   import ifstmt_seq_accum_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 3
) (
   input  logic [1:0]       sel_q,
   input  logic [CW-1:0]    cnt,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] acc_next
);

   // Step selection; order of the tests matters and must stay as written.
   always_comb begin
      acc_next = acc;
      if (eq(32'(sel_q), 32'(MODE_ADD))) begin
         acc_next = acc + x;
      end else if (eq(32'(sel_q), 32'(MODE_ADD1))) begin
         if (eq(32'(cnt), 32'd0)) begin
            acc_next = x;
         end else begin
            acc_next = acc + x + WIDTH'(32'd1);
         end
      end else if (eq(32'(sel_q), 32'(MODE_INC2))) begin
         acc_next = acc + WIDTH'(32'd2);
      end else begin
         acc_next = acc;
      end
   end

endmodule

// File: rtl/ifstmt_seq_accum.sv
// Start-triggered FSM running COUNT accumulation steps, then pulsing done with the result.
module ifstmt_seq_accum
   import ifstmt_seq_accum_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int COUNT = 4
) (
   input logic               clock,
   input logic               reset,
   ifstmt_seq_accum_if.slave bus
);

   localparam int            CW   = clog2(COUNT + 1);
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] acc_next;

   ifstmt_seq_step #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_step (
      .sel_q    (sel_q),
      .cnt      (cnt_q),
      .acc      (acc_q),
      .x        (bus.x),
      .acc_next (acc_next)
   );

   // Next-state and datapath update for IDLE/RUN/DONE.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sel_d   = bus.sel;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = acc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               a_d     = acc_next;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any run in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         sel_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
      end
   end

   assign bus.a    = a_q;
   assign bus.done = done_q;
   assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifstmt_seq_accum.sv
// Vector table plus scoreboard for 32-bit and 8-bit accumulator instances.
module tb_ifstmt_seq_accum;

   localparam int COUNT = 4;

   typedef struct {
      bit          is8;
      logic [1:0]  sel;
      logic [31:0] x;
      logic [31:0] exp;
      bit          noisy;
   } vec_t;

   logic clock;
   logic rst32;
   logic rst8;

   int checks  = 0;
   int errors  = 0;
   int runs32  = 0;
   int runs8   = 0;
   int dones32 = 0;
   int dones8  = 0;

   logic [31:0] exp_q32[$];
   logic [7:0]  exp_q8[$];
   vec_t        tbl[11];

   ifstmt_seq_accum_if #(.WIDTH(32)) bus32 ();
   ifstmt_seq_accum_if #(.WIDTH(8))  bus8 ();

   ifstmt_seq_accum #(.WIDTH(32), .COUNT(COUNT)) dut32 (
      .clock (clock),
      .reset (rst32),
      .bus   (bus32)
   );

   ifstmt_seq_accum #(.WIDTH(8), .COUNT(COUNT)) dut8 (
      .clock (clock),
      .reset (rst8),
      .bus   (bus8)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_a(input bit is8);
      if (is8) return {24'd0, bus8.a};
      else     return bus32.a;
   endfunction

   function automatic logic get_busy(input bit is8);
      if (is8) return bus8.busy;
      else     return bus32.busy;
   endfunction

   function automatic logic get_done(input bit is8);
      if (is8) return bus8.done;
      else     return bus32.done;
   endfunction

   task automatic drive(input bit is8, input logic st, input logic [1:0] s, input logic [31:0] xv);
      if (is8) begin
         bus8.start = st;
         bus8.sel   = s;
         bus8.x     = xv[7:0];
      end else begin
         bus32.start = st;
         bus32.sel   = s;
         bus32.x     = xv;
      end
   endtask

   // Scoreboard: every done pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      if (bus32.done === 1'b1) begin
         dones32 = dones32 + 1;
         if (exp_q32.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done32_unexpected: got done with a=%0h expected no done", bus32.a);
         end else begin
            check("a32_at_done", bus32.a, exp_q32.pop_front());
         end
      end
      if (bus8.done === 1'b1) begin
         dones8 = dones8 + 1;
         if (exp_q8.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done8_unexpected: got done with a=%0h expected no done", bus8.a);
         end else begin
            check("a8_at_done", {24'd0, bus8.a}, {24'd0, exp_q8.pop_front()});
         end
      end
   end

   task automatic run_one(input vec_t v);
      logic [1:0] s;
      s = v.sel;
      @(negedge clock);
      drive(v.is8, 1'b1, s, v.x);
      if (v.is8) begin
         exp_q8.push_back(v.exp[7:0]);
         runs8 = runs8 + 1;
      end else begin
         exp_q32.push_back(v.exp);
         runs32 = runs32 + 1;
      end
      for (int i = 1; i <= COUNT + 1; i++) begin
         @(negedge clock);
         check("run_busy", 32'(get_busy(v.is8)), 32'd1);
         check("run_done", 32'(get_done(v.is8)), 32'(i == COUNT + 1));
         if (v.noisy) begin
            s = s ^ 2'b01;
            drive(v.is8, 1'b1, s, v.x);
         end else begin
            drive(v.is8, 1'b0, s, v.x);
         end
      end
      @(negedge clock);
      drive(v.is8, 1'b0, s, v.x);
      check("idle_busy", 32'(get_busy(v.is8)), 32'd0);
      repeat (2) begin
         @(negedge clock);
         check("idle_hold_a", get_a(v.is8), v.exp);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b0, 2'd0, 32'd5,          32'd20,         1'b0};
      tbl[1]  = '{1'b0, 2'd1, 32'd5,          32'd23,         1'b0};
      tbl[2]  = '{1'b0, 2'd2, 32'h0000_1234,  32'd8,          1'b0};
      tbl[3]  = '{1'b0, 2'd3, 32'd77,         32'd0,          1'b0};
      tbl[4]  = '{1'b0, 2'd1, 32'd5,          32'd23,         1'b1};
      tbl[5]  = '{1'b0, 2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFC,  1'b0};
      tbl[6]  = '{1'b0, 2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
      tbl[7]  = '{1'b1, 2'd0, 32'd255,        32'd252,        1'b0};
      tbl[8]  = '{1'b1, 2'd1, 32'd200,        32'd35,         1'b0};
      tbl[9]  = '{1'b1, 2'd2, 32'd99,         32'd8,          1'b1};
      tbl[10] = '{1'b1, 2'd3, 32'd1,          32'd0,          1'b0};

      rst32 = 1'b1;
      rst8  = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 32'd0);
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      repeat (2) @(negedge clock);
      check("rst32_a",    bus32.a,            32'd0);
      check("rst32_busy", 32'(bus32.busy),    32'd0);
      check("rst32_done", 32'(bus32.done),    32'd0);
      check("rst8_a",     {24'd0, bus8.a},    32'd0);
      check("rst8_busy",  32'(bus8.busy),     32'd0);
      rst32 = 1'b0;
      rst8  = 1'b0;

      for (int k = 0; k < 11; k++) begin
         run_one(tbl[k]);
      end

      // Reset in the second RUN cycle of a sel=0 run: no result may escape.
      @(negedge clock);
      drive(1'b0, 1'b1, 2'd0, 32'd5);
      @(negedge clock);
      drive(1'b0, 1'b0, 2'd0, 32'd5);
      @(negedge clock);
      rst32 = 1'b1;
      @(negedge clock);
      check("midrst_busy", 32'(bus32.busy), 32'd0);
      check("midrst_a",    bus32.a,         32'd0);
      check("midrst_done", 32'(bus32.done), 32'd0);
      rst32 = 1'b0;
      for (int i = 0; i < COUNT + 3; i++) begin
         @(negedge clock);
         check("postrst_no_done", 32'(bus32.done), 32'd0);
      end
      run_one('{1'b0, 2'd0, 32'd5, 32'd20, 1'b0});

      // Start held high: two runs separated by exactly one IDLE cycle.
      @(negedge clock);
      drive(1'b0, 1'b1, 2'd0, 32'd5);
      exp_q32.push_back(32'd20);
      exp_q32.push_back(32'd20);
      runs32 = runs32 + 2;
      for (int i = 1; i <= 2 * (COUNT + 2); i++) begin
         @(negedge clock);
         check("b2b_busy", 32'(bus32.busy), 32'((i % (COUNT + 2)) != 0));
         if (i == 2 * (COUNT + 2)) drive(1'b0, 1'b0, 2'd0, 32'd5);
      end
      repeat (COUNT + 3) @(negedge clock);
      check("b2b_idle_busy", 32'(bus32.busy), 32'd0);

      check("q32_empty", 32'(exp_q32.size()), 32'd0);
      check("q8_empty",  32'(exp_q8.size()),  32'd0);
      check("dones32",   32'(dones32),        32'(runs32));
      check("dones8",    32'(dones8),         32'(runs8));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifstmt_seq_accum.md
Name: ifstmt_seq_accum

Overview:
- Clocked, parametrised successor to the single-shot constant-condition if/else testcase.
- A three-state FSM runs COUNT accumulation steps after a start pulse.
- Each step is chosen by nested if/else chains on equality-function calls over a latched mode and the step counter.
- Serves as a sequential stimulus module for the if-statement simplification and function-inlining passes, and must also simulate correctly as ordinary RTL.

Parameters:
- WIDTH, 32, bit width of x, the accumulator and output a.
- COUNT, 4, number of RUN steps per start; legal range 1..255.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- sel  input  2  mode; latched into sel_q on accepted start.
- x  input  WIDTH  operand, sampled every RUN cycle.
- a  output  WIDTH  result register.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; a is valid in the same cycle.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All flops are updated only on the rising edge of clock.
- Reset (sampled high at an edge):
  - state=IDLE, acc=0, cnt=0, sel_q=0, a=0, done=0.
  - busy=0 from the next cycle.
  - Reset overrides every other input, including mid-RUN and during DONE; no partial result reaches a.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: sel_q<=sel, acc<=0, cnt<=0, state<=RUN.
  - Otherwise hold; a keeps its last value.
- RUN: each edge computes acc_next from the equality function eq(p,q)=(p==q), evaluated strictly in this order:
  - if eq(sel_q,0): acc+x
  - else if eq(sel_q,1):
    - if eq(cnt,0): x
    - else: acc+x+1
  - else if eq(sel_q,2): acc+2
  - else: acc (hold)
- RUN updates: acc<=acc_next and cnt<=cnt+1.
- Last RUN step (cnt==COUNT-1): additionally a<=acc_next, done<=1, state<=DONE.
- DONE: lasts one cycle; done<=0, state<=IDLE.
- Latency: start accepted at edge k → RUN for cycles k+1..k+COUNT → done=1 and a final during cycle k+COUNT+1. A new start is accepted at the earliest at the edge ending that DONE cycle + 1, i.e. while back in IDLE.
- start while busy (RUN or DONE) is ignored. sel changes during RUN are ignored because sel_q is used.
- Arithmetic is unsigned modulo 2^WIDTH; wrap-around is silent. The x+1 and +2 constants are zero-extended to WIDTH.
- cnt width: clog2(COUNT+1), computed by a constant function inside the module.
- Simulation only: when done=1, display a once (non-synthesisable, inside a translate-off region).

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=0, ST_RUN=1, ST_DONE=2 (2-bit).
  - mode constants MODE_ADD=0, MODE_ADD1=1, MODE_INC2=2, MODE_HOLD=3.
  - the eq and clog2 functions.
- Sub-module ifstmt_seq_step (combinational):
  - inputs sel_q, cnt, acc, x; output acc_next.
  - contains the nested if/else chain, so the passes see it both inlined and as an instance.

Test Plan:
1. WIDTH=32, COUNT=4, sel=0, x=5 held, start pulse at edge 0 → busy=1 cycles 1-5; done=1 only in cycle 5 with a=20; busy=0 in cycle 6.
2. sel=1, x=5 → acc sequence 5, 11, 17, 23; a=23 with done.
3. sel=2, x=anything → a=8. Then sel=3 → a=0. Between runs, a holds its previous value while in IDLE.
4. WIDTH=8, COUNT=4, sel=0, x=255 → a=252 (wrap). Then sel=1, x=200 → acc 200, 145, 90, 35; a=35.
5. Reset raised in cycle 2 of a sel=0 run → next cycle: busy=0, a=0, done=0, no done pulse afterwards. Start after reset yields a clean result of 20.
6. start re-asserted every cycle during RUN, and sel toggled mid-run → exactly one done per accepted start; result uses the sel latched at start. Back-to-back: start held high → runs separated by exactly one IDLE cycle.
